// File: rtl/temporal_pkg.sv
// temporal_pkg: shared types and helpers for the temporal (rising-edge-coded) mux blocks
package temporal_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, ENC, PULSE, RESP} sched_state_t;
  function automatic int gamma_period(input int gcw, input int pw);
    return gcw + pw + 1;
  endfunction
endpackage

// File: rtl/gamma_timebase.sv
// gamma_timebase: free-running gamma-cycle counter with boundary strobe and mux counter reset
module gamma_timebase #(
  parameter int PERIOD = 25,
  parameter int CW     = $clog2(PERIOD)
) (
  input  logic          aclk,
  input  logic          grst_n,
  output logic [CW-1:0] gcnt,
  output logic          gamma_start,
  output logic          mux_rst
);
  logic [CW-1:0] r_gcnt;
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) r_gcnt <= '0;
    else         r_gcnt <= (r_gcnt == CW'(PERIOD - 1)) ? '0 : r_gcnt + 1'b1;
  end
  assign gcnt        = r_gcnt;
  assign gamma_start = (r_gcnt == '0);
  // the mux counter must also be held cleared while the block itself is in reset
  assign mux_rst     = gamma_start | ~grst_n;
endmodule

// File: rtl/temporal_read_sched.sv
// temporal_read_sched: encodes a read index as a select-line rise time within a gamma cycle
// and returns the word the temporal mux presents at that rise
module temporal_read_sched
  import temporal_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  parameter  int PULSE_WIDTH       = 8,
  parameter  int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
  parameter  int BUS_WIDTH         = 8,
  localparam int IDX_W             = $clog2(NUM_INPUTS),
  localparam int P                 = gamma_period(GAMMA_CYCLE_WIDTH, PULSE_WIDTH)
) (
  input  logic                 aclk,
  input  logic                 grst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W:0]       req_idx,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_data,
  output logic [IDX_W:0]       rsp_idx,
  output logic                 rsp_err,
  output logic                 mux_rst,
  output logic                 select_line,
  input  logic [BUS_WIDTH-1:0] mux_y,
  output logic                 gamma_start
);
  localparam int GW   = $clog2(P);
  localparam int IW   = IDX_W + 1;
  localparam int PW_W = $clog2(PULSE_WIDTH + 1);

  sched_state_t         r_state, w_next;
  logic [GW-1:0]        w_gcnt;
  logic [PW_W-1:0]      r_pcnt;
  logic [IW-1:0]        r_idx;
  logic                 r_err, r_sel;
  logic [BUS_WIDTH-1:0] r_data;

  gamma_timebase #(.PERIOD(P), .CW(GW)) u_tb (
    .aclk        (aclk),
    .grst_n      (grst_n),
    .gcnt        (w_gcnt),
    .gamma_start (gamma_start),
    .mux_rst     (mux_rst)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = ARMED;
      // idx 0 must rise at gcnt 1, so it skips the low encoding phase entirely
      ARMED:   if (gamma_start) w_next = (r_idx == '0) ? PULSE : ENC;
      ENC:     if (r_err ? (w_gcnt == GW'(P - 2)) : (IW'(w_gcnt) == r_idx)) w_next = r_err ? RESP : PULSE;
      PULSE:   if (r_pcnt == PW_W'(PULSE_WIDTH - 1)) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_pcnt  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_sel   <= (w_next == PULSE);
      r_pcnt  <= (r_state == PULSE) ? r_pcnt + 1'b1 : '0;
      if (r_state == IDLE && req_valid) begin
        r_idx  <= req_idx;
        r_err  <= (req_idx >= IW'(NUM_INPUTS));
        r_data <= '0;
      end
      // only the first high cycle carries the selected input; later mux_y is ignored
      if (r_state == PULSE && r_pcnt == '0) r_data <= mux_y;
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  assign select_line = r_sel;
  assign rsp_data    = r_data;
  assign rsp_idx     = r_idx;
  assign rsp_err     = r_err;
endmodule

// File: tb/tb_temporal_read_sched.sv
// tb_temporal_read_sched: table-driven reads against a behavioural temporal mux, with a response scoreboard
module tb_temporal_read_sched;
  localparam int P  = 25;
  localparam int PW = 8;

  typedef struct {
    logic [4:0] idx;
    int         k;
    int         hold;
    logic [7:0] data;
    logic       err;
  } vec_t;
  typedef struct {
    logic [7:0] data;
    logic [4:0] idx;
    logic       err;
  } exp_t;

  logic       aclk = 1'b0, grst_n = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [4:0] req_idx = '0;
  logic       req_ready, rsp_valid, rsp_err, mux_rst, select_line, gamma_start;
  logic [4:0] rsp_idx;
  logic [7:0] rsp_data, mux_y;
  logic [3:0] mcnt, hage;
  int         tg;
  int         total = 0, bad = 0;
  exp_t       q[$];
  vec_t       vecs[10];

  always #5 aclk = ~aclk;

  temporal_read_sched dut (
    .aclk        (aclk),
    .grst_n      (grst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_idx     (req_idx),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_idx     (rsp_idx),
    .rsp_err     (rsp_err),
    .mux_rst     (mux_rst),
    .select_line (select_line),
    .mux_y       (mux_y),
    .gamma_start (gamma_start)
  );

  // mux: counts while select is low, freezes while high; high-age term makes late captures visible
  always @(posedge aclk) begin
    if (mux_rst) mcnt <= '0;
    else if (!select_line) mcnt <= mcnt + 1'b1;
    hage <= select_line ? hage + 1'b1 : 4'd0;
  end
  assign mux_y = 8'hA0 + {4'h0, mcnt} + {hage, 4'h0};

  always @(posedge aclk or negedge grst_n) begin
    if (!grst_n) tg <= 0;
    else         tg <= (tg == P - 1) ? 0 : tg + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v);
    int   n, k, rise, hi;
    exp_t e;
    n = 0;
    while (!(req_ready && (v.k < 0 || tg == v.k)) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("accept_wait_ok", n < 200, 1);
    rsp_ready = (v.hold == 0);
    req_valid = 1'b1;
    req_idx   = v.idx;
    k         = tg;
    q.push_back('{v.data, v.idx, v.err});
    @(negedge aclk);
    req_valid = 1'b0;
    n = 1; rise = -1; hi = 0;
    while (!rsp_valid && n < 120) begin
      chk("gamma_start", gamma_start, tg == 0);
      chk("mux_rst", mux_rst, tg == 0);
      if (select_line) begin
        if (rise < 0) rise = tg;
        hi++;
      end
      @(negedge aclk);
      n++;
    end
    chk("rsp_latency", n, P - k + (v.err ? P - 1 : v.idx + PW + 1));
    chk("rsp_gcnt", tg, v.err ? P - 1 : v.idx + PW + 1);
    chk("sel_rise_gcnt", rise, v.err ? -1 : v.idx + 1);
    chk("sel_high_len", hi, v.err ? 0 : PW);
    for (int h = 0; h < v.hold; h++) begin
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, q[0].data);
      chk("bp_select", select_line, 0);
      @(negedge aclk);
    end
    rsp_ready = 1'b1;
    e = q.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_idx", rsp_idx, e.idx);
    chk("rsp_err", rsp_err, e.err);
    chk("hs_req_ready", req_ready, 0);
    @(negedge aclk);
    chk("post_req_ready", req_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    int n, seen;
    vecs[0] = '{5'd5,  3,  0,  8'hA5, 1'b0};
    vecs[1] = '{5'd0,  10, 0,  8'hA0, 1'b0};
    vecs[2] = '{5'd15, -1, 0,  8'hAF, 1'b0};
    vecs[3] = '{5'd16, 0,  0,  8'h00, 1'b1};
    vecs[4] = '{5'd31, 24, 0,  8'h00, 1'b1};
    vecs[5] = '{5'd7,  24, 0,  8'hA7, 1'b0};
    vecs[6] = '{5'd15, 0,  0,  8'hAF, 1'b0};
    vecs[7] = '{5'd9,  -1, 75, 8'hA9, 1'b0};
    vecs[8] = '{5'd2,  -1, 0,  8'hA2, 1'b0};
    vecs[9] = '{5'd12, -1, 3,  8'hAC, 1'b0};
    #2 grst_n = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_select", select_line, 0);
    chk("rst_mux_rst", mux_rst, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_idx", rsp_idx, 0);
    chk("rst_rsp_err", rsp_err, 0);
    grst_n = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    chk("rel_gamma_start", gamma_start, 1);
    @(negedge aclk);
    foreach (vecs[i]) run(vecs[i]);
    // reset in the middle of a pulse drops the request
    n = 0;
    while (!(req_ready && tg == 3) && n < 100) begin @(negedge aclk); n++; end
    req_valid = 1'b1;
    req_idx   = 5'd10;
    @(negedge aclk);
    req_valid = 1'b0;
    n = 0;
    while (!select_line && n < 100) begin @(negedge aclk); n++; end
    chk("mid_pulse_reached", select_line, 1);
    repeat (2) @(negedge aclk);
    grst_n = 1'b0;
    #1;
    chk("mid_rst_select", select_line, 0);
    chk("mid_rst_mux_rst", mux_rst, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge aclk);
    grst_n = 1'b1;
    #1;
    chk("mid_rel_req_ready", req_ready, 1);
    chk("mid_rel_gamma_start", gamma_start, 1);
    seen = 0;
    repeat (60) begin
      @(negedge aclk);
      if (rsp_valid || select_line || !req_ready) seen++;
    end
    chk("no_activity_after_rst", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
